// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Register-address width derivation and packed-slice indexing.
package pipe_pkg;

  localparam int unsigned REG_ZERO = 0;

  function automatic int unsigned ra_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned lsb_of(
    input int unsigned k,
    input int unsigned w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_mux.sv
// Single-operand priority forwarding mux; source 0 is youngest.
// Falls back to the register-file value; x0 is never forwarded.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned RA_W      = 5
) (
  input  logic [RA_W-1:0]           rs_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [FWD_DEPTH-1:0]      src_we_i,
  input  logic [FWD_DEPTH*RA_W-1:0] src_rd_i,
  input  logic [FWD_DEPTH*XLEN-1:0] src_data_i,
  output logic [XLEN-1:0]           op_o
);

  // Walk from the oldest source so the lowest index wins.
  always_comb begin
    op_o = rf_data_i;
    if (rs_i != RA_W'(REG_ZERO)) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (src_we_i[k] &&
            src_rd_i[lsb_of(k, RA_W) +: RA_W] == rs_i)
          op_o = src_data_i[lsb_of(k, XLEN) +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load scoreboard, stall/flush and operand forwarding control.
// Define HAZ_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 1,
  localparam int unsigned RA_W     = ra_w(NREG)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      id_valid_i,
  input  logic [RA_W-1:0]           id_rs1_i,
  input  logic [RA_W-1:0]           id_rs2_i,
  input  logic                      id_use_rs1_i,
  input  logic                      id_use_rs2_i,
  input  logic [RA_W-1:0]           id_rd_i,
  input  logic                      id_load_i,
  input  logic [RA_W-1:0]           ex_rs1_i,
  input  logic [RA_W-1:0]           ex_rs2_i,
  input  logic [XLEN-1:0]           ex_rs1_data_i,
  input  logic [XLEN-1:0]           ex_rs2_data_i,
  input  logic [FWD_DEPTH-1:0]      src_we_i,
  input  logic [FWD_DEPTH*RA_W-1:0] src_rd_i,
  input  logic [FWD_DEPTH*XLEN-1:0] src_data_i,
  input  logic                      redirect_i,
  output logic                      stall_if_o,
  output logic                      stall_id_o,
  output logic                      bubble_ex_o,
  output logic                      flush_if_o,
  output logic                      flush_id_o,
  output logic                      flush_ex_o,
  output logic [XLEN-1:0]           op_a_o,
  output logic [XLEN-1:0]           op_b_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(LOAD_LAT + 1);

  if (LOAD_LAT == 0 || LOAD_LAT > FWD_DEPTH) begin : g_bad_lat
    $error("pipe_hazard_ctrl: LOAD_LAT out of range");
  end

  logic [CW-1:0]   busy_q [1:NREG-1];
  logic [CW-1:0]   busy_d [1:NREG-1];
  logic [NREG-1:0] busy_nz;
  logic            ex_load_vld_q, ex_load_vld_d;
  logic [RA_W-1:0] ex_load_rd_q, ex_load_rd_d;
  logic            hazard, stall, dispatch, kill;

  always_comb begin
    busy_nz = '0;
    for (int r = 1; r < NREG; r++)
      busy_nz[r] = (busy_q[r] != '0);
  end

  assign hazard = id_valid_i &
                  ((id_use_rs1_i & busy_nz[id_rs1_i]) |
                   (id_use_rs2_i & busy_nz[id_rs2_i]));
  assign stall    = hazard & ~redirect_i;
  assign dispatch = id_valid_i & id_load_i &
                    (id_rd_i != RA_W'(REG_ZERO)) &
                    ~stall & ~redirect_i;
  // The load one cycle ahead is younger than the redirecting branch.
  assign kill     = redirect_i & ex_load_vld_q;

  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      busy_d[r] = busy_q[r];
      if (busy_q[r] != '0)
        busy_d[r] = busy_q[r] - CW'(1);
      if (kill && ex_load_rd_q == RA_W'(r))
        busy_d[r] = '0;
      if (dispatch && id_rd_i == RA_W'(r))
        busy_d[r] = CW'(LOAD_LAT);
    end
    ex_load_vld_d = dispatch;
    ex_load_rd_d  = id_rd_i;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_q        <= '{default: '0};
      ex_load_vld_q <= 1'b0;
      ex_load_rd_q  <= '0;
    end else begin
      busy_q        <= busy_d;
      ex_load_vld_q <= ex_load_vld_d;
      ex_load_rd_q  <= ex_load_rd_d;
    end
  end

  assign stall_if_o  = stall;
  assign stall_id_o  = stall;
  assign bubble_ex_o = stall;
  assign flush_if_o  = redirect_i;
  assign flush_id_o  = redirect_i;
  assign flush_ex_o  = redirect_i;

  fwd_mux #(
    .XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .RA_W(RA_W)
  ) u_fwd_a (
    .rs_i      (ex_rs1_i),
    .rf_data_i (ex_rs1_data_i),
    .src_we_i  (src_we_i),
    .src_rd_i  (src_rd_i),
    .src_data_i(src_data_i),
    .op_o      (op_a_o)
  );

  fwd_mux #(
    .XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .RA_W(RA_W)
  ) u_fwd_b (
    .rs_i      (ex_rs2_i),
    .rf_data_i (ex_rs2_data_i),
    .src_we_i  (src_we_i),
    .src_rd_i  (src_rd_i),
    .src_data_i(src_data_i),
    .op_o      (op_b_o)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_i};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
